// File: rtl/speed_display_driver.sv
// Assembles NUL-terminated ASCII-decimal speed frames from the receiver byte
// stream and scans them onto a multiplexed common-anode 7-segment display.
module speed_display_driver #(
   parameter int unsigned NUM_DIGITS  = 3,
   parameter int unsigned REFRESH_DIV = 384,
   parameter int unsigned TIMEOUT     = 2048
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            msg,
   input  logic                  noti,
   output logic [6:0]            seg_n,
   output logic [NUM_DIGITS-1:0] dig_n,
   output logic                  frame_ok,
   output logic                  frame_err
);

   localparam int unsigned CNT_W = $clog2(NUM_DIGITS + 1);
   localparam int unsigned STG_W = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDL_W = $clog2(TIMEOUT + 1);
   localparam logic [3:0]  BLANK = 4'hF;

   typedef enum logic {RECV, DISCARD} state_e;

   state_e                       state_q, state_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [STG_W-1:0]             stage_q, stage_d;
   logic [NUM_DIGITS-1:0][3:0]   disp_q, disp_d;
   logic [IDL_W-1:0]             idle_q, idle_d;
   logic [REF_W-1:0]             ref_q, ref_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [6:0]                   seg_n_q, seg_n_d;
   logic [NUM_DIGITS-1:0]        dig_n_q, dig_n_d;
   logic                         ok_q, ok_d, err_q, err_d;
   logic                         is_digit_c, is_nul_c, timeout_c, commit_c;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'h40;
         4'd1:    seg_of = 7'h79;
         4'd2:    seg_of = 7'h24;
         4'd3:    seg_of = 7'h30;
         4'd4:    seg_of = 7'h19;
         4'd5:    seg_of = 7'h12;
         4'd6:    seg_of = 7'h02;
         4'd7:    seg_of = 7'h78;
         4'd8:    seg_of = 7'h00;
         4'd9:    seg_of = 7'h10;
         default: seg_of = 7'h7F;
      endcase
   endfunction

   assign is_digit_c = (msg >= 8'h30) && (msg <= 8'h39);
   assign is_nul_c   = (msg == 8'h00);
   // A byte arriving in the same cycle always beats the timeout.
   assign timeout_c  = !noti && (idle_q == IDL_W'(TIMEOUT)) &&
                       (((state_q == RECV) && (cnt_q != '0)) || (state_q == DISCARD));

   always_ff @(posedge clk) begin
      if (rst) state_q <= RECV;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (noti) begin
         case (state_q)
            RECV: begin
               if (is_digit_c && (cnt_q == CNT_W'(NUM_DIGITS))) state_d = DISCARD;
               else if (!is_digit_c && !is_nul_c)                state_d = DISCARD;
            end
            DISCARD: if (is_nul_c) state_d = RECV;
            default: state_d = RECV;
         endcase
      end else if (timeout_c) begin
         state_d = RECV;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      stage_d  = stage_q;
      commit_c = 1'b0;
      ok_d     = 1'b0;
      err_d    = 1'b0;
      if (noti) begin
         case (state_q)
            RECV: begin
               if (is_digit_c) begin
                  if (cnt_q < CNT_W'(NUM_DIGITS)) begin
                     stage_d = (stage_q << 4) | STG_W'(msg[3:0]);
                     cnt_d   = cnt_q + CNT_W'(1);
                  end else begin
                     err_d   = 1'b1;
                     cnt_d   = '0;
                     stage_d = '0;
                  end
               end else if (is_nul_c) begin
                  if (cnt_q != '0) begin
                     commit_c = 1'b1;
                     ok_d     = 1'b1;
                     cnt_d    = '0;
                     stage_d  = '0;
                  end
               end else begin
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  stage_d = '0;
               end
            end
            default: begin
               cnt_d   = '0;
               stage_d = '0;
            end
         endcase
      end else if (timeout_c) begin
         err_d   = (state_q == RECV);
         cnt_d   = '0;
         stage_d = '0;
      end
   end

   // Commit right-aligns the staged digits and blanks the unused upper ones.
   always_comb begin
      disp_d = disp_q;
      if (commit_c) begin
         for (int i = 0; i < int'(NUM_DIGITS); i++)
            disp_d[i] = (i < int'(cnt_q)) ? stage_q[4*i +: 4] : BLANK;
      end
   end

   always_comb begin
      idle_d = noti ? '0 : ((idle_q == IDL_W'(TIMEOUT)) ? idle_q : idle_q + IDL_W'(1));
      ref_d  = (ref_q == REF_W'(REFRESH_DIV - 1)) ? '0 : ref_q + REF_W'(1);
      idx_d  = idx_q;
      if (ref_q == REF_W'(REFRESH_DIV - 1))
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      dig_n_d = ~(NUM_DIGITS'(1) << idx_q);
      seg_n_d = seg_of(disp_q[idx_q]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         stage_q <= '0;
         disp_q  <= {NUM_DIGITS{BLANK}};
         idle_q  <= '0;
         ref_q   <= '0;
         idx_q   <= '0;
         seg_n_q <= 7'h7F;
         dig_n_q <= ~NUM_DIGITS'(1);
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         disp_q  <= disp_d;
         idle_q  <= idle_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         seg_n_q <= seg_n_d;
         dig_n_q <= dig_n_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
      end
   end

   assign seg_n     = seg_n_q;
   assign dig_n     = dig_n_q;
   assign frame_ok  = ok_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_speed_display_driver.sv
// Bench for speed_display_driver: frame events are scoreboarded, the display
// is checked by watching the scan outputs.
module tb_speed_display_driver;

   localparam int EV_OK  = 1;
   localparam int EV_ERR = 2;
   localparam int BL     = 15;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] msg;
   logic       noti;
   logic [6:0] seg_n;
   logic [2:0] dig_n;
   logic       frame_ok;
   logic       frame_err;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int cyc = 0;
   int noti_cyc = 0;
   int err_cyc = -1;
   int got_ev;
   int exp_ev;

   speed_display_driver #(.NUM_DIGITS(3), .REFRESH_DIV(384), .TIMEOUT(2048)) dut (
      .clk       (clk),
      .rst       (rst),
      .msg       (msg),
      .noti      (noti),
      .seg_n     (seg_n),
      .dig_n     (dig_n),
      .frame_ok  (frame_ok),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Every frame pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (rst === 1'b0 && (frame_ok === 1'b1 || frame_err === 1'b1)) begin
         got_ev = (frame_ok && frame_err) ? 3 : (frame_ok ? EV_OK : EV_ERR);
         if (frame_err) err_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got event %0d at cycle %0d, required none", got_ev, cyc);
         end else begin
            exp_ev = exp_q.pop_front();
            if (got_ev != exp_ev) begin
               errors++;
               $display("FAIL event_kind: got %0d, required %0d (1=ok 2=err)", got_ev, exp_ev);
            end
         end
      end
   end

   function automatic logic [6:0] seg_model(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [20:0] exp3(input int d2, input int d1, input int d0);
      return {seg_model(d2), seg_model(d1), seg_model(d0)};
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge clk); #1;
      msg  = b;
      noti = 1'b1;
      @(posedge clk); #1;
      noti = 1'b0;
      noti_cyc = cyc;
      repeat (gap) @(posedge clk);
   endtask

   // Collects seg_n for digit 0, then 1, then 2 as the scan reaches each.
   task automatic observe_scan(output logic [20:0] segs);
      logic [2:0] pat;
      int n;
      segs = '0;
      for (int i = 0; i < 3; i++) begin
         pat = 3'b001 << i;
         pat = ~pat;
         n = 0;
         @(negedge clk);
         while (dig_n !== pat && n < 1300) begin
            @(negedge clk);
            n++;
         end
         if (n >= 1300) segs[7*i +: 7] = 7'bx;
         else           segs[7*i +: 7] = seg_n;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; msg = 8'h00; noti = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (seg_n !== 7'h7F)  begin errors++; $display("FAIL reset_seg: got %h, required 7f", seg_n); end
      checks++; if (dig_n !== 3'b110) begin errors++; $display("FAIL reset_dig: got %b, required 110", dig_n); end
      checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b, required 0", frame_ok); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", frame_err); end
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [20:0] s;
      send_byte(8'h31, 88);
      send_byte(8'h32, 88);
      exp_q.push_back(EV_OK);
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, 1, 2)) begin errors++; $display("FAIL basic_12: got %h, required %h", s, exp3(BL, 1, 2)); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_events: %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back;
      logic [20:0] s;
      send_byte(8'h34, 88);
      send_byte(8'h35, 88);
      exp_q.push_back(EV_OK);
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, 4, 5)) begin errors++; $display("FAIL b2b_45: got %h, required %h", s, exp3(BL, 4, 5)); end
      send_byte(8'h37, 2);
      send_byte(8'h38, 2);
      exp_q.push_back(EV_OK);
      send_byte(8'h00, 2);
      observe_scan(s);
      checks++; if (s !== exp3(BL, 7, 8)) begin errors++; $display("FAIL b2b_78: got %h, required %h", s, exp3(BL, 7, 8)); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_events: %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_bad_char;
      logic [20:0] s;
      send_byte(8'h31, 88);
      exp_q.push_back(EV_ERR);
      send_byte(8'h41, 88);
      send_byte(8'h32, 88);
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, 7, 8)) begin errors++; $display("FAIL bad_hold: got %h, required %h", s, exp3(BL, 7, 8)); end
      send_byte(8'h39, 88);
      exp_q.push_back(EV_OK);
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, BL, 9)) begin errors++; $display("FAIL bad_next9: got %h, required %h", s, exp3(BL, BL, 9)); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bad_events: %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_overflow;
      logic [20:0] s;
      send_byte(8'h31, 88);
      send_byte(8'h32, 88);
      send_byte(8'h33, 88);
      exp_q.push_back(EV_ERR);
      send_byte(8'h34, 88);
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, BL, 9)) begin errors++; $display("FAIL ovf_hold: got %h, required %h", s, exp3(BL, BL, 9)); end
      send_byte(8'h30, 88);
      send_byte(8'h35, 88);
      exp_q.push_back(EV_OK);
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, 0, 5)) begin errors++; $display("FAIL lead_zero: got %h, required %h", s, exp3(BL, 0, 5)); end
      send_byte(8'h31, 88);
      send_byte(8'h32, 88);
      send_byte(8'h33, 88);
      exp_q.push_back(EV_OK);
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(1, 2, 3)) begin errors++; $display("FAIL full_123: got %h, required %h", s, exp3(1, 2, 3)); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_events: %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_timeout;
      logic [20:0] s;
      int t0;
      exp_q.push_back(EV_ERR);
      send_byte(8'h36, 2100);
      t0 = noti_cyc;
      checks++; if (err_cyc - t0 != 2049) begin errors++; $display("FAIL timeout_latency: got %0d, required 2049", err_cyc - t0); end
      send_byte(8'h37, 88);
      exp_q.push_back(EV_OK);
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, BL, 7)) begin errors++; $display("FAIL timeout_next7: got %h, required %h", s, exp3(BL, BL, 7)); end
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, BL, 7)) begin errors++; $display("FAIL lone_nul: got %h, required %h", s, exp3(BL, BL, 7)); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_events: %0d pending, required 0", exp_q.size()); end
   endtask

   task automatic test_reset_mid_frame;
      logic [20:0] s;
      send_byte(8'h31, 88);
      send_byte(8'h32, 88);
      @(posedge clk); #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (seg_n !== 7'h7F)  begin errors++; $display("FAIL mid_rst_seg: got %h, required 7f", seg_n); end
      checks++; if (dig_n !== 3'b110) begin errors++; $display("FAIL mid_rst_dig: got %b, required 110", dig_n); end
      @(posedge clk); #1 rst = 1'b0;
      observe_scan(s);
      checks++; if (s !== exp3(BL, BL, BL)) begin errors++; $display("FAIL mid_rst_blank: got %h, required %h", s, exp3(BL, BL, BL)); end
      send_byte(8'h00, 88);
      observe_scan(s);
      checks++; if (s !== exp3(BL, BL, BL)) begin errors++; $display("FAIL mid_rst_nul: got %h, required %h", s, exp3(BL, BL, BL)); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mid_rst_events: %0d pending, required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_bad_char();
      test_overflow();
      test_timeout();
      test_reset_mid_frame();
      repeat (10) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
